// File: rtl/mask_pkg.sv
// Shared widths and the MSB-aligned thermometer decode for the mask_16_32 block.
//   MASK16_W / MASK32_W : mask widths
//   CNT16_W  / CNT32_W  : matching count widths
//   msb_mask(width, n)  : top n+1 bits of a width-bit word set, rest clear
package mask_pkg;

    localparam int unsigned MASK16_W = 16;
    localparam int unsigned MASK32_W = 32;
    localparam int unsigned CNT16_W  = 4;
    localparam int unsigned CNT32_W  = 5;

    // Bit i is set iff i >= width-1-n; written as i+n+1 >= width so nothing underflows.
    function automatic logic [31:0] msb_mask(input int unsigned width, input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < width) && ((i + n + 1) >= width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mask_unit.sv
// One mask channel: combinational thermometer decode feeding a registered output.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears mask
//   cnt  : binary count n (CW bits)
//   mask : registered W-bit mask with the top n+1 bits set
module mask_unit
    import mask_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt,
    output logic [W-1:0]  mask
);

    logic [W-1:0] mask_c;

    // Decode the count into an MSB-aligned thermometer mask.
    always_comb begin
        mask_c = W'(msb_mask(W, 32'(cnt)));
    end

    // Output register; reset is the only way to reach all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else begin
            mask <= mask_c;
        end
    end

endmodule

// File: rtl/mask_16_32.sv
// Two independent registered MSB-aligned thermometer masks, 16-bit and 32-bit.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears both masks
//   in16   : 4-bit count for mask16
//   in32   : 5-bit count for mask32
//   mask16 : registered 16-bit mask, top in16+1 bits set
//   mask32 : registered 32-bit mask, top in32+1 bits set
module mask_16_32
    import mask_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT16_W-1:0]  in16,
    input  logic [CNT32_W-1:0]  in32,
    output logic [MASK16_W-1:0] mask16,
    output logic [MASK32_W-1:0] mask32
);

    mask_unit #(.W(MASK16_W), .CW(CNT16_W)) u_mask16 (
        .clk  (clk),
        .rst  (rst),
        .cnt  (in16),
        .mask (mask16)
    );

    mask_unit #(.W(MASK32_W), .CW(CNT32_W)) u_mask32 (
        .clk  (clk),
        .rst  (rst),
        .cnt  (in32),
        .mask (mask32)
    );

endmodule

// File: tb/tb_mask_16_32.sv
// Self-checking bench for mask_16_32: directed cases plus randomized streaming
// against an arithmetic reference model.
module tb_mask_16_32;

    logic        clk;
    logic        rst;
    logic [3:0]  in16;
    logic [4:0]  in32;
    logic [15:0] mask16;
    logic [31:0] mask32;

    int checks   = 0;
    int failures = 0;

    mask_16_32 dut (
        .clk    (clk),
        .rst    (rst),
        .in16   (in16),
        .in32   (in32),
        .mask16 (mask16),
        .mask32 (mask32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: all bits at or above position W-1-n, i.e. ~((1 << (W-1-n)) - 1).
    function automatic logic [15:0] ref16(input int n);
        logic [63:0] v;
        v = ~((64'd1 << (15 - n)) - 64'd1);
        return v[15:0];
    endfunction

    function automatic logic [31:0] ref32(input int n);
        logic [63:0] v;
        v = ~((64'd1 << (31 - n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] e16;
        logic [31:0] e32;

        rst  = 1'b1;
        in16 = 4'hF;
        in32 = 5'h1F;

        // Reset holds outputs at zero regardless of inputs.
        tick();
        check_eq("rst0_m16", 32'(mask16), 32'h0);
        check_eq("rst0_m32", mask32, 32'h0);
        tick();
        check_eq("rst1_m16", 32'(mask16), 32'h0);
        check_eq("rst1_m32", mask32, 32'h0);

        rst = 1'b0;

        // Directed 16-bit decode against literal expectations.
        in16 = 4'd0;  in32 = 5'd0;  tick(); check_eq("d16_0",  32'(mask16), 32'h8000);
                                             check_eq("d32_0",  mask32, 32'h8000_0000);
        in16 = 4'd3;  tick();                check_eq("d16_3",  32'(mask16), 32'hF000);
        in16 = 4'd7;  tick();                check_eq("d16_7",  32'(mask16), 32'hFF00);
        in16 = 4'd15; tick();                check_eq("d16_15", 32'(mask16), 32'hFFFF);

        // Cross-width sweep: mask32 is mask16 shifted into the upper half.
        for (int x = 0; x < 16; x++) begin
            in16 = 4'(x);
            in32 = 5'(x);
            tick();
            check_eq($sformatf("xw_m16_%0d", x), 32'(mask16), 32'(ref16(x)));
            check_eq($sformatf("xw_cat_%0d", x), mask32, {mask16, 16'h0000});
            check_eq($sformatf("xw_lo_%0d", x), 32'(mask32[15:0]), 32'h0);
        end

        // 32-bit upper range spills into the lower half.
        in32 = 5'd16; tick(); check_eq("d32_16", mask32, 32'hFFFF_8000);
        in32 = 5'd24; tick(); check_eq("d32_24", mask32, 32'hFFFF_FF80);
        in32 = 5'd31; tick(); check_eq("d32_31", mask32, 32'hFFFF_FFFF);

        // Mid-stream reset.
        in16 = 4'd7; in32 = 5'd7;
        tick();
        check_eq("ms_pre_m16", 32'(mask16), 32'hFF00);
        check_eq("ms_pre_m32", mask32, 32'hFF00_0000);
        rst = 1'b1;
        tick();
        check_eq("ms_rst_m16", 32'(mask16), 32'h0);
        check_eq("ms_rst_m32", mask32, 32'h0);
        rst = 1'b0;
        tick();
        check_eq("ms_post_m16", 32'(mask16), 32'hFF00);
        check_eq("ms_post_m32", mask32, 32'hFF00_0000);

        // Random streaming, new input every cycle.
        for (int c = 0; c < 1000; c++) begin
            in16 = 4'($urandom_range(0, 15));
            in32 = 5'($urandom_range(0, 31));
            e16  = ref16(int'(in16));
            e32  = ref32(int'(in32));
            tick();
            check_eq($sformatf("rnd_m16_%0d", c), 32'(mask16), 32'(e16));
            check_eq($sformatf("rnd_m32_%0d", c), mask32, e32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
